// File: rtl/poly_tone_mixer.sv
// poly_tone_mixer: NUM_CH square-wave tone channels, each with a gate-driven
// attack/release envelope and a stereo pan setting, mixed into one saturated
// signed stereo sample pair for the DAC/I2S serialiser.

// One tone channel: phase divider, envelope ramp and signed sample.
module poly_tone_ch #(
  parameter int DIV_W    = 20,
  parameter int VOL_W    = 15,
  parameter int AUDIO_W  = 16,
  parameter int ATK_STEP = 64,
  parameter int REL_STEP = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_tick,
  input  logic [DIV_W-1:0]   i_div,
  input  logic [VOL_W-1:0]   i_vol,
  input  logic               i_gate,
  output logic [AUDIO_W-1:0] o_smp,
  output logic               o_nz
);
  // Envelope arithmetic runs one bit wider than the envelope, so the extra
  // bit is the carry of an attack step or the borrow of a release step.
  localparam int E_W = VOL_W + 1;

  logic [DIV_W-1:0]   r_cnt;
  logic               r_phase;
  logic [VOL_W-1:0]   r_env;
  logic               r_gate_d;

  logic               w_muted;
  logic               w_rise;
  logic [E_W-1:0]     w_env;
  logic [E_W-1:0]     w_vol;
  logic [E_W-1:0]     w_up;
  logic [E_W-1:0]     w_dn;
  logic [VOL_W-1:0]   w_env_nxt;
  logic [AUDIO_W-1:0] w_mag;

  assign w_muted = (i_div == '0);
  assign w_rise  = i_gate & ~r_gate_d;
  assign w_env   = {1'b0, r_env};
  assign w_vol   = {1'b0, i_vol};
  assign w_up    = w_env + E_W'(ATK_STEP);
  assign w_dn    = w_env - E_W'(REL_STEP);

  // Next envelope: ramp towards the volume while gated, towards 0 when not;
  // the clamps stop any overshoot past the target and any wrap below 0.
  always_comb begin
    w_env_nxt = r_env;
    if (i_tick) begin
      if (i_gate) begin
        if (w_env < w_vol)
          w_env_nxt = (w_up > w_vol) ? i_vol : w_up[VOL_W-1:0];
        else if (w_env > w_vol)
          w_env_nxt = (w_dn[VOL_W] || (w_dn < w_vol)) ? i_vol : w_dn[VOL_W-1:0];
      end else begin
        w_env_nxt = w_dn[VOL_W] ? '0 : w_dn[VOL_W-1:0];
      end
    end
  end

  // Phase divider; a new note restarts high, and >= lets a shrinking divider
  // wrap at once instead of counting through the whole counter range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_phase  <= 1'b0;
      r_env    <= '0;
      r_gate_d <= 1'b0;
    end else begin
      r_gate_d <= i_gate;
      r_env    <= w_env_nxt;
      if (w_muted) begin
        r_cnt   <= '0;
        r_phase <= 1'b0;
      end else if (w_rise) begin
        r_cnt   <= '0;
        r_phase <= 1'b1;
      end else if (r_cnt >= i_div) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt   <= r_cnt + DIV_W'(1);
      end
    end
  end

  assign w_mag = {{(AUDIO_W-VOL_W){1'b0}}, r_env};
  assign o_smp = w_muted ? '0 : (r_phase ? w_mag : (~w_mag + AUDIO_W'(1)));
  assign o_nz  = (r_env != '0);
endmodule

// Top: shared envelope prescaler, channel array, pan routing and mixer.
module poly_tone_mixer #(
  parameter int NUM_CH   = 2,
  parameter int DIV_W    = 20,
  parameter int VOL_W    = 15,
  parameter int AUDIO_W  = 16,
  parameter int ENV_DIV  = 4096,
  parameter int ATK_STEP = 64,
  parameter int REL_STEP = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*DIV_W-1:0] note_div,
  input  logic [NUM_CH*VOL_W-1:0] volumn,
  input  logic [NUM_CH-1:0]       gate,
  input  logic [2*NUM_CH-1:0]     pan,
  output logic [AUDIO_W-1:0]      audio_left,
  output logic [AUDIO_W-1:0]      audio_right,
  output logic [NUM_CH-1:0]       active
);
  localparam int PS_W  = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
  localparam int SUM_W = AUDIO_W + $clog2(NUM_CH);
  localparam int PAD_W = SUM_W - AUDIO_W + 1;

  localparam logic signed [SUM_W-1:0] SAT_HI = {{PAD_W{1'b0}}, {(AUDIO_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_LO = {{PAD_W{1'b1}}, {(AUDIO_W-1){1'b0}}};

  logic [PS_W-1:0]                 r_ps;
  logic                            w_tick;
  logic [NUM_CH-1:0][AUDIO_W-1:0]  w_smp;
  logic [NUM_CH-1:0]               w_nz;
  logic signed [SUM_W-1:0]         w_sum_l;
  logic signed [SUM_W-1:0]         w_sum_r;
  logic [AUDIO_W-1:0]              r_left;
  logic [AUDIO_W-1:0]              r_right;
  logic [NUM_CH-1:0]               r_active;

  assign w_tick = (r_ps == PS_W'(ENV_DIV - 1));

  // Free-running envelope prescaler shared by every channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_ps <= '0;
    else if (w_tick) r_ps <= '0;
    else             r_ps <= r_ps + PS_W'(1);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    poly_tone_ch #(
      .DIV_W   (DIV_W),
      .VOL_W   (VOL_W),
      .AUDIO_W (AUDIO_W),
      .ATK_STEP(ATK_STEP),
      .REL_STEP(REL_STEP)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .i_tick(w_tick),
      .i_div (note_div[i*DIV_W +: DIV_W]),
      .i_vol (volumn[i*VOL_W +: VOL_W]),
      .i_gate(gate[i]),
      .o_smp (w_smp[i]),
      .o_nz  (w_nz[i])
    );
  end

  // Pan routing: 01 drops the channel from the right bus, 10 from the left.
  always_comb begin
    w_sum_l = '0;
    w_sum_r = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pan[2*i +: 2] != 2'b10) w_sum_l = w_sum_l + SUM_W'($signed(w_smp[i]));
      if (pan[2*i +: 2] != 2'b01) w_sum_r = w_sum_r + SUM_W'($signed(w_smp[i]));
    end
  end

  function automatic logic [AUDIO_W-1:0] sat(input logic signed [SUM_W-1:0] s);
    if (s > SAT_HI)      sat = SAT_HI[AUDIO_W-1:0];
    else if (s < SAT_LO) sat = SAT_LO[AUDIO_W-1:0];
    else                 sat = s[AUDIO_W-1:0];
  endfunction

  // Clip the mixed buses and register them with the activity flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_left   <= '0;
      r_right  <= '0;
      r_active <= '0;
    end else begin
      r_left   <= sat(w_sum_l);
      r_right  <= sat(w_sum_r);
      r_active <= w_nz;
    end
  end

  assign audio_left  = r_left;
  assign audio_right = r_right;
  assign active      = r_active;
endmodule

// File: tb/tb_poly_tone_mixer.sv
// Bench for poly_tone_mixer: a behavioural reference model predicts every
// output sample, expectations are queued at each clock edge and retired
// against the DUT shortly after the edge.
module tb_poly_tone_mixer;
  localparam int ENV_DIV = 4;
  localparam int STEP    = 'h1000;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [1:0]  a;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] nd  [2];
  logic [14:0] vol [2];
  logic [1:0]  pn  [2];
  logic [1:0]  g;
  logic [39:0] note_div;
  logic [29:0] volumn;
  logic [3:0]  pan;
  logic [15:0] al, ar;
  logic [1:0]  act;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  int m_cnt [2];
  bit m_ph  [2];
  int m_env [2];
  bit m_gd  [2];
  int m_ps;

  assign note_div = {nd[1], nd[0]};
  assign volumn   = {vol[1], vol[0]};
  assign pan      = {pn[1], pn[0]};

  poly_tone_mixer #(
    .NUM_CH(2), .DIV_W(20), .VOL_W(15), .AUDIO_W(16),
    .ENV_DIV(ENV_DIV), .ATK_STEP(STEP), .REL_STEP(STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .note_div(note_div), .volumn(volumn),
    .gate(g), .pan(pan), .audio_left(al), .audio_right(ar), .active(act)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input int x);
    if (x > 32767)  return 16'h7fff;
    if (x < -32768) return 16'h8000;
    return x[15:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_ph[i] = 0; m_env[i] = 0; m_gd[i] = 0;
    end
    m_ps = 0;
  endtask

  // Reference behaviour for one rising edge with the inputs currently applied.
  task automatic model_edge(output exp_t e);
    int s, sl, sr;
    bit tk;
    sl = 0; sr = 0;
    for (int i = 0; i < 2; i++) begin
      s = (nd[i] == 0) ? 0 : (m_ph[i] ? m_env[i] : -m_env[i]);
      if (pn[i] != 2'b10) sl += s;
      if (pn[i] != 2'b01) sr += s;
    end
    e.l = sat16(sl);
    e.r = sat16(sr);
    e.a = {m_env[1] != 0, m_env[0] != 0};
    tk = (m_ps == ENV_DIV - 1);
    m_ps = tk ? 0 : m_ps + 1;
    for (int i = 0; i < 2; i++) begin
      if (nd[i] == 0)                  begin m_cnt[i] = 0; m_ph[i] = 0; end
      else if (g[i] && !m_gd[i])       begin m_cnt[i] = 0; m_ph[i] = 1; end
      else if (m_cnt[i] >= int'(nd[i])) begin m_cnt[i] = 0; m_ph[i] = !m_ph[i]; end
      else                             m_cnt[i]++;
      if (tk) begin
        if (g[i]) begin
          if (m_env[i] < int'(vol[i]))
            m_env[i] = (m_env[i] + STEP > int'(vol[i])) ? int'(vol[i]) : m_env[i] + STEP;
          else if (m_env[i] > int'(vol[i]))
            m_env[i] = (m_env[i] - STEP < int'(vol[i])) ? int'(vol[i]) : m_env[i] - STEP;
        end else begin
          m_env[i] = (m_env[i] - STEP < 0) ? 0 : m_env[i] - STEP;
        end
      end
      m_gd[i] = g[i];
    end
  endtask

  // One clock: queue the prediction at the edge, retire it 1 ns later.
  task automatic step();
    exp_t e, o;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
      e.l = '0; e.r = '0; e.a = '0;
    end else begin
      model_edge(e);
    end
    sb.push_back(e);
    #1;
    o = sb.pop_front();
    chk("left",   al,  o.l);
    chk("right",  ar,  o.r);
    chk("active", act, o.a);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    int bound;
    rst_n = 1'b0;
    g = '0;
    for (int i = 0; i < 2; i++) begin nd[i] = '0; vol[i] = '0; pn[i] = 2'b00; end
    model_reset();
    #1;
    chk("rst_left",   al,  16'h0);
    chk("rst_right",  ar,  16'h0);
    chk("rst_active", act, 2'b00);
    run(3);
    #2 rst_n = 1'b1;
    run(2);

    // single channel tone, period 8, envelope one step
    nd[0] = 20'd3; vol[0] = 15'h1000; g[0] = 1'b1;
    run(40);
    chk("t1_active", act, 2'b01);

    // ramp to 0x3000, then release down to 0 without underflow
    vol[0] = 15'h3000;
    run(20);
    g[0] = 1'b0;
    run(24);
    chk("t3_idle", act, 2'b00);

    // attack clamps at a non-multiple target, then a held volume drop
    vol[0] = 15'h1800; g[0] = 1'b1;
    run(20);
    vol[0] = 15'h0800;
    run(16);

    // divider shortened while cnt is past the new value, then muted
    vol[0] = 15'h1000; nd[0] = 20'h100;
    bound = 0;
    while (m_cnt[0] != 'h50 && bound < 2000) begin step(); bound++; end
    chk("t4_reach_cnt", (bound < 2000), 1'b1);
    nd[0] = 20'h2;
    run(30);
    nd[0] = 20'h0;
    run(10);
    chk("t4_muted", al, 16'h0);
    g[0] = 1'b0;
    run(20);

    // pan isolation: ch0 left only, ch1 right only
    nd[0] = 20'd3; nd[1] = 20'd5;
    vol[0] = 15'h1000; vol[1] = 15'h1000;
    pn[0] = 2'b01; pn[1] = 2'b10;
    g = 2'b11;
    run(40);
    g = 2'b00;
    run(20);

    // saturation of two full-scale channels on both buses
    pn[0] = 2'b00; pn[1] = 2'b00;
    nd[0] = 20'd5; nd[1] = 20'd5;
    vol[0] = 15'h7fff; vol[1] = 15'h7fff;
    g = 2'b11;
    run(80);

    // asynchronous reset mid-tone, then restart on a new gate edge
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_left",   al,  16'h0);
    chk("t6_async_right",  ar,  16'h0);
    chk("t6_async_active", act, 2'b00);
    model_reset();
    run(3);
    g = 2'b00;
    #2 rst_n = 1'b1;
    run(10);
    chk("t6_quiet", al, 16'h0);
    g = 2'b01;
    run(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/poly_tone_mixer.md
Name: poly_tone_mixer

Overview:
- Multi-channel square-wave tone generator with per-channel envelope, stereo pan and a saturating mixer.
- Parametrised successor to the single-tone buzzer driver; feeds the audio DAC/I2S serialiser with signed stereo samples.
- Each channel uses the same divider scheme as the buzzer (toggle when counter reaches note_div, period 2*(note_div+1) clocks).
- Adds gate-driven attack/release ramps, channel muting, panning and a mixer that clips instead of wrapping.

Parameters:
- NUM_CH, 2, number of tone channels (1..8)
- DIV_W, 20, note divider width
- VOL_W, 15, per-channel volume/envelope width (unsigned)
- AUDIO_W, 16, output sample width, two's complement; must be > VOL_W
- ENV_DIV, 4096, clocks per envelope tick (>=1)
- ATK_STEP, 64, envelope increment per tick while gated
- REL_STEP, 64, envelope decrement per tick

Ports:
- clk  input  1  system clock from crystal
- rst_n  input  1  asynchronous active-low reset
- note_div  input  NUM_CH*DIV_W  per-channel half-period minus one; channel i at [i*DIV_W +: DIV_W]; 0 = muted
- volumn  input  NUM_CH*VOL_W  per-channel target amplitude
- gate  input  NUM_CH  per-channel note on (1) / release (0)
- pan  input  2*NUM_CH  per-channel pan: 00 both, 01 left only, 10 right only, 11 both
- audio_left  output  AUDIO_W  signed left sample
- audio_right  output  AUDIO_W  signed right sample
- active  output  NUM_CH  channel envelope nonzero

Behaviour:
- Clock and reset: single clock domain; rst_n asynchronous assert, synchronous deassert handled upstream.
- Reset values: all counters, phases, envelopes, gate_d, prescaler = 0; audio_left = audio_right = 0; active = 0.
- Phase generator, per channel (cnt DIV_W bits, phase 1 bit):
  - note_div==0: cnt and phase held at 0.
  - gate rising edge (gate & ~gate_d): cnt<=0, phase<=1. This has priority over everything below.
  - cnt >= note_div: cnt<=0, phase toggles. The >= means that lowering note_div below cnt wraps on the next cycle, with no 2^DIV_W run-out.
  - otherwise: cnt<=cnt+1.
- Envelope prescaler: counts 0..ENV_DIV-1; tick=1 in the cycle it equals ENV_DIV-1, then wraps to 0. It is free-running and shared by all channels.
- Envelope update, on tick only, computed at VOL_W+1 bits:
  - gate=1, env<vol: env = min(env+ATK_STEP, vol).
  - gate=1, env>vol: env = max(env-REL_STEP, vol), so a volume drop while held ramps down.
  - gate=1, env==vol: hold.
  - gate=0: env = max(env-REL_STEP, 0).
  - The envelope never overshoots its target and never wraps.
- Channel sample: 0 if note_div==0; otherwise +env when phase=1, -env when phase=0, sign-extended to AUDIO_W.
- Mixer:
  - left sum = sum of samples with pan in {00,01,11}; right sum = sum with pan in {00,10,11}.
  - Sums are AUDIO_W+clog2(NUM_CH) wide.
  - Saturate to [-2^(AUDIO_W-1), 2^(AUDIO_W-1)-1].
  - Register the result into audio_left/audio_right.
- Latency: outputs reflect the phase/env registers of the previous cycle (1 clock).
- active[i] = (env[i]!=0), registered alongside the audio outputs.
- Simultaneous events:
  - A gate rising edge and a tick in the same cycle: phase restarts and the envelope steps up in that same cycle.
  - A gate drop and a tick in the same cycle: the release step applies in that cycle.
- Reset mid-operation: all state clears immediately on rst_n low. Outputs read 0 while reset is held.

Test Plan (NUM_CH=2, ENV_DIV=4, ATK_STEP=REL_STEP=0x1000 unless stated):
1. ch0 note_div=3, volumn=0x1000, gate0 0->1, ch1 gate=0 -> first tick env0=0x1000; audio_left/right alternate +0x1000 / 0xF000 every 4 clocks (period 8); active=01.
2. Both channels note_div=5, volumn=0x7FFF, ATK_STEP=0x7FFF, gates raised same cycle, pan=00 -> audio=0x7FFF when high, 0x8000 when low (saturated, no wrap).
3. ch0 at env 0x3000, gate0 1->0 -> env 0x2000, 0x1000, 0 on successive ticks; active[0] falls one clock after env reaches 0; no underflow.
4. ch0 playing, note_div changed 0x100 -> 0x2 while cnt=0x50 -> phase toggles the next cycle, then period 6; note_div=0 -> contribution 0, cnt held.
5. ch0 pan=01, ch1 pan=10, both gated at 0x1000 -> audio_left carries only ch0, audio_right only ch1.
6. Assert rst_n low mid-tone, asynchronous to clk -> audio_left/right and active go 0 without a clock edge; after release, tone resumes only on a new gate rising edge and tick.
